// File: rtl/arb_ctrl_if.sv
// ---------------------------------------------------------------------------
// arb_ctrl_if -- request/grant bundle between two bus clients and arb_ctrl.
//
// Signals:
//   i_req0, i_req1 : client bus requests
//   i_ready        : current bus transfer completes this cycle
//   o_grant0/1     : one-hot selection of the next master
//   o_master       : current bus owner (0 = client 0, 1 = client 1)
//   o_state        : arbiter FSM state (IDLE=0, OWN=1, HANDOFF=2)
//   o_starve       : sticky starvation watchdog flag
//
// Modports:
//   master : client / driver side (drives requests and ready)
//   slave  : arbiter side (drives grants and status)
// ---------------------------------------------------------------------------
interface arb_ctrl_if;
  logic       i_req0;
  logic       i_req1;
  logic       i_ready;
  logic       o_grant0;
  logic       o_grant1;
  logic       o_master;
  logic [1:0] o_state;
  logic       o_starve;

  modport master (
    output i_req0, i_req1, i_ready,
    input  o_grant0, o_grant1, o_master, o_state, o_starve
  );

  modport slave (
    input  i_req0, i_req1, i_ready,
    output o_grant0, o_grant1, o_master, o_state, o_starve
  );
endinterface

// File: rtl/arb_ctrl.sv
// ---------------------------------------------------------------------------
// arb_ctrl -- two-client bus arbiter with tenure limit and starvation watchdog.
//
// The arbiter keeps a "next master" select (gsel) that becomes the bus owner
// on the cycle after a completed transfer (i_ready). A master keeps the bus
// for at most TENURE consecutive ready-handovers while the other client is
// waiting. Once a switch has been decided (HANDOFF) it is committed until the
// next i_ready so the grants never glitch.
//
// Parameters:
//   TENURE     : max consecutive handovers kept while the other client waits (1..7)
//   WDOG_LIMIT : wait-cycle count that trips o_starve (2..15)
//
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : arb_ctrl_if.slave (requests/ready in, grants/master/state/starve out)
//
// Optional feature macro: ARB_STARVE_WDOG_EN
//   defined   -> per-client 4-bit wait counters and sticky o_starve flag
//   undefined -> no wait counters, o_starve tied to 0
// ---------------------------------------------------------------------------
module arb_ctrl #(
  parameter int TENURE     = 4,
  parameter int WDOG_LIMIT = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  arb_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_HANDOFF = 2'd2
  } state_e;

  localparam logic [2:0] TENURE_C = 3'(TENURE);

  state_e     state_q, state_d;
  logic       gsel_q, gsel_d;
  logic       master_q, master_d;
  logic [2:0] tenure_q, tenure_d;
  logic       req_own_s;
  logic       req_oth_s;

  // Next-select, next-owner, tenure and next-state evaluation.
  always_comb begin
    req_own_s = master_q ? bus.i_req1 : bus.i_req0;
    req_oth_s = master_q ? bus.i_req0 : bus.i_req1;

    // Ownership only moves on a completed transfer.
    if (bus.i_ready) begin
      master_d = gsel_q;
    end else begin
      master_d = master_q;
    end

    if (gsel_q != master_q) begin
      // A pending switch is held until the transfer completes.
      gsel_d = gsel_q;
    end else if ((state_q == ST_IDLE) && bus.i_req0 && bus.i_req1) begin
      // Simultaneous requests from idle go round-robin.
      gsel_d = ~master_q;
    end else if (req_oth_s && (!req_own_s || (tenure_q == TENURE_C))) begin
      gsel_d = ~master_q;
    end else if (req_own_s) begin
      gsel_d = master_q;
    end else if (req_oth_s) begin
      gsel_d = ~master_q;
    end else begin
      gsel_d = gsel_q;
    end

    // Tenure only accumulates while the other client is actually waiting.
    if ((master_d != master_q) || !req_oth_s) begin
      tenure_d = 3'd0;
    end else if (bus.i_ready && (tenure_q < TENURE_C)) begin
      tenure_d = tenure_q + 3'd1;
    end else begin
      tenure_d = tenure_q;
    end

    // State is a function of the values being registered on this same edge.
    if (gsel_d != master_d) begin
      state_d = ST_HANDOFF;
    end else if (bus.i_req0 || bus.i_req1) begin
      state_d = ST_OWN;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      gsel_q   <= 1'b0;
      master_q <= 1'b0;
      tenure_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      gsel_q   <= gsel_d;
      master_q <= master_d;
      tenure_q <= tenure_d;
    end
  end

  assign bus.o_grant1 = gsel_q;
  assign bus.o_grant0 = ~gsel_q;
  assign bus.o_master = master_q;
  assign bus.o_state  = state_q;

`ifdef ARB_STARVE_WDOG_EN
  localparam logic [3:0] WDOG_C = 4'(WDOG_LIMIT);

  logic [3:0] wait0_q, wait0_d;
  logic [3:0] wait1_q, wait1_d;
  logic       starve_q, starve_d;

  // Saturating 4-bit increment.
  function automatic logic [3:0] sat_inc4(input logic [3:0] val);
    if (val == 4'hF) begin
      return 4'hF;
    end else begin
      return val + 4'd1;
    end
  endfunction

  // Wait counters run while a client requests but is not the owner.
  always_comb begin
    if (bus.i_req0 && (master_q != 1'b0)) begin
      wait0_d = sat_inc4(wait0_q);
    end else begin
      wait0_d = 4'd0;
    end
    if (bus.i_req1 && (master_q != 1'b1)) begin
      wait1_d = sat_inc4(wait1_q);
    end else begin
      wait1_d = 4'd0;
    end
    // Flag is sticky; it trips the cycle after a counter reaches the limit.
    starve_d = starve_q || (wait0_q >= WDOG_C) || (wait1_q >= WDOG_C);
  end

  // Watchdog registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait0_q  <= 4'd0;
      wait1_q  <= 4'd0;
      starve_q <= 1'b0;
    end else begin
      wait0_q  <= wait0_d;
      wait1_q  <= wait1_d;
      starve_q <= starve_d;
    end
  end

  assign bus.o_starve = starve_q;
`else
  assign bus.o_starve = 1'b0;
`endif

endmodule
